// File: rtl/game_pkg.sv
// Shared types and constants for the game-settings register bus.
package game_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_ABORT   = 2'd2
  } arb_state_t;

  // Settings register map (even byte addresses)
  localparam logic [ADDR_W-1:0] ROW_COLUMN_NUMBER = 8'h00;
  localparam logic [ADDR_W-1:0] GAME_MODE         = 8'h02;
  localparam logic [ADDR_W-1:0] DIFFICULTY        = 8'h04;
  localparam logic [ADDR_W-1:0] PLAYER_ONE_COLOR  = 8'h06;
  localparam logic [ADDR_W-1:0] PLAYER_TWO_COLOR  = 8'h08;
  localparam logic [ADDR_W-1:0] TURN_TIMER        = 8'h0A;
  localparam logic [ADDR_W-1:0] SOUND_LEVEL       = 8'h0C;
  localparam logic [ADDR_W-1:0] GAMES_PLAYED      = 8'h0E;
  localparam logic [ADDR_W-1:0] GAMES_WON         = 8'h10;
  localparam logic [ADDR_W-1:0] GAMES_LOST        = 8'h12;

  typedef struct packed {
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone link between the arbiter and the settings register slave.
interface wishbone_if;
  import game_pkg::*;

  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              ack_i;

  modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i);
  modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i);
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request at or after ptr, wrapping to bit 0.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c
);

  logic [NUM_REQ-1:0] below_ptr;
  logic [NUM_REQ-1:0] upper_req;

  // Lowest set bit of the upper half first, else lowest set bit overall.
  always_comb begin
    below_ptr = (NUM_REQ'(1) << ptr) - NUM_REQ'(1);
    upper_req = req & ~below_ptr;
    if (upper_req != '0) begin
      grant_c = upper_req & (~upper_req + NUM_REQ'(1));
    end else begin
      grant_c = req & (~req + NUM_REQ'(1));
    end
  end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin Wishbone arbiter for several masters sharing the settings slave,
// with a no-ack timeout that aborts the transfer and flags the owner.
module settings_bus_arbiter
  import game_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_cyc,
  input  logic [NUM_MASTERS-1:0]              m_stb,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_adr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_dat_w,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_err,
  output logic [DATA_W-1:0]                   m_dat_r,
  wishbone_if.master                          s_bus,
  output logic [NUM_MASTERS-1:0]              grant
);

  localparam int unsigned PTR_W  = $clog2(NUM_MASTERS);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t              state;
  arb_state_t              state_nxt;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [NUM_MASTERS-1:0]  grant_nxt;
  logic [NUM_MASTERS-1:0]  pick;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        ptr_nxt;
  logic [PTR_W-1:0]        owner_idx;
  logic [PTR_W-1:0]        ptr_after_owner;
  logic [TCNT_W-1:0]       tcnt;
  logic [TCNT_W-1:0]       tcnt_nxt;
  wb_req_t                 owner_req;

  rr_priority_picker #(
    .NUM_REQ (NUM_MASTERS),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (m_cyc),
    .ptr     (rr_ptr),
    .grant_c (pick)
  );

  // Owner's request, selected by the registered one-hot grant.
  always_comb begin
    owner_req = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        owner_idx     = PTR_W'(i);
        owner_req.cyc = m_cyc[i];
        owner_req.stb = m_stb[i];
        owner_req.we  = m_we[i];
        owner_req.adr = m_adr[i];
        owner_req.dat = m_dat_w[i];
      end
    end
    ptr_after_owner = (owner_idx == PTR_W'(NUM_MASTERS - 1)) ? '0
                                                             : owner_idx + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= ptr_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    ptr_nxt     = rr_ptr;
    tcnt_nxt    = tcnt;
    m_ack       = '0;
    m_err       = '0;
    grant       = '0;
    s_bus.cyc_o = 1'b0;
    s_bus.stb_o = 1'b0;
    s_bus.we_o  = 1'b0;
    s_bus.adr_o = '0;
    s_bus.dat_o = '0;

    unique case (state)
      ST_IDLE: begin
        if (m_cyc != '0) begin
          grant_nxt = pick;
          tcnt_nxt  = '0;
          state_nxt = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        // Owner release wins over ack and timeout.
        if (!owner_req.cyc) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          ptr_nxt   = ptr_after_owner;
        end else if (s_bus.ack_i) begin
          tcnt_nxt = '0;
        end else if (owner_req.stb) begin
          tcnt_nxt = tcnt + TCNT_W'(1);
          if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        ptr_nxt   = ptr_after_owner;
        tcnt_nxt  = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase

    // Outputs are forced quiet while reset is asserted.
    if (!rst) begin
      grant = grant_q;
      if (state == ST_GRANTED) begin
        s_bus.cyc_o = owner_req.cyc;
        s_bus.stb_o = owner_req.stb;
        s_bus.we_o  = owner_req.we;
        s_bus.adr_o = owner_req.adr;
        s_bus.dat_o = owner_req.dat;
        if (s_bus.ack_i) begin
          m_ack = grant_q;
        end
      end
      if (state == ST_ABORT) begin
        m_err = grant_q;
      end
    end
  end

  assign m_dat_r = s_bus.dat_i;

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Bench for settings_bus_arbiter: vector table, directed corner sequences,
// then random traffic against a cycle-level reference model.
module tb_settings_bus_arbiter;
  import game_pkg::*;

  localparam int unsigned N  = 3;
  localparam int          TO = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           m_cyc, m_stb, m_we;
  logic [N-1:0][7:0]      m_adr;
  logic [N-1:0][15:0]     m_dat_w;
  logic [N-1:0]           m_ack, m_err, grant;
  logic [15:0]            m_dat_r;

  wishbone_if wb ();

  settings_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_dat_r (m_dat_r),
    .s_bus   (wb),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs just after the edge; outputs settle before the next edge.
  task automatic drive(input logic r, input logic [N-1:0] c, input logic [N-1:0] s,
                       input logic a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst = r; m_cyc = c; m_stb = s; wb.ack_i = a; wb.dat_i = d;
    #1;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] c;
    logic [N-1:0] s;
    logic         a;
    logic [15:0]  d;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ack;
    logic         e_cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] c, input logic [N-1:0] s, input logic a,
                     input logic [15:0] d, input logic [N-1:0] eg, input logic [N-1:0] ea,
                     input logic ec);
    vec_t v;
    v.r = r; v.c = c; v.s = s; v.a = a; v.d = d;
    v.e_grant = eg; v.e_ack = ea; v.e_cyc = ec;
    tbl.push_back(v);
  endtask

  // Reference model: owner index (-1 idle), abort flag, pointer and wait count.
  int mo, mptr, mwait;
  bit mab;

  task automatic model_reset();
    mo = -1; mab = 1'b0; mptr = 0; mwait = 0;
  endtask

  task automatic model_step();
    int i;
    if (rst) begin
      model_reset();
    end else if (mab) begin
      mptr = (mo + 1) % N; mo = -1; mab = 1'b0; mwait = 0;
    end else if (mo < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (mptr + k) % N;
        if (mo < 0 && m_cyc[i]) mo = i;
      end
      mwait = 0;
    end else if (!m_cyc[mo]) begin
      mptr = (mo + 1) % N; mo = -1;
    end else if (wb.ack_i) begin
      mwait = 0;
    end else if (m_stb[mo]) begin
      mwait++;
      if (mwait == TO) mab = 1'b1;
    end
  endtask

  task automatic model_compare();
    logic [N-1:0] oh, eg, ea, ee;
    logic ec, es, ew;
    logic [7:0] eadr;
    logic [15:0] edat;
    bit active;
    oh = '0; eg = '0; ea = '0; ee = '0; ec = 0; es = 0; ew = 0; eadr = '0; edat = '0;
    if (!rst && mo >= 0) begin
      oh = N'(1) << mo;
      eg = oh;
      active = !mab;
      if (mab) ee = oh;
      if (active) begin
        if (wb.ack_i) ea = oh;
        ec = m_cyc[mo]; es = m_stb[mo]; ew = m_we[mo];
        eadr = m_adr[mo]; edat = m_dat_w[mo];
      end
    end
    chk("rnd_grant", 32'(grant), 32'(eg));
    chk("rnd_ack",   32'(m_ack), 32'(ea));
    chk("rnd_err",   32'(m_err), 32'(ee));
    chk("rnd_cyc_o", 32'(wb.cyc_o), 32'(ec));
    chk("rnd_stb_o", 32'(wb.stb_o), 32'(es));
    chk("rnd_we_o",  32'(wb.we_o), 32'(ew));
    chk("rnd_adr_o", 32'(wb.adr_o), 32'(eadr));
    chk("rnd_dat_o", 32'(wb.dat_o), 32'(edat));
    chk("rnd_dat_r", 32'(m_dat_r), 32'(wb.dat_i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t0, t1;
  bit saw_ack, stall;
  logic [N-1:0] rc, rs;
  logic ra, rr;

  initial begin
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
    wb.ack_i = 1'b0; wb.dat_i = '0;
    m_adr[0] = ROW_COLUMN_NUMBER; m_adr[1] = DIFFICULTY; m_adr[2] = GAMES_LOST;
    for (int i = 0; i < N; i++) m_dat_w[i] = 16'(16'h1000 + i);

    // Per-cycle vectors: reset, single read, three-way round robin, withdrawn request.
    add(1, 3'b000, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b010, 3'b010, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b010, 3'b010, 1, 16'h0096, 3'b010, 3'b010, 1);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b010, 3'b000, 0);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(1, 3'b000, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b111, 3'b111, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b111, 3'b111, 1, 16'h0011, 3'b001, 3'b001, 1);
    add(0, 3'b110, 3'b110, 0, 16'h0000, 3'b001, 3'b000, 0);
    add(0, 3'b110, 3'b110, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b110, 3'b110, 1, 16'h0022, 3'b010, 3'b010, 1);
    add(0, 3'b100, 3'b100, 0, 16'h0000, 3'b010, 3'b000, 0);
    add(0, 3'b100, 3'b100, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b100, 3'b100, 1, 16'h0033, 3'b100, 3'b100, 1);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b100, 3'b000, 0);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b011, 3'b011, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b001, 3'b001, 0, 16'h0000, 3'b001, 3'b000, 1);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b001, 3'b000, 0);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0);
    add(0, 3'b000, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].c, tbl[k].s, tbl[k].a, tbl[k].d);
      chk($sformatf("vec%0d_grant", k), 32'(grant), 32'(tbl[k].e_grant));
      chk($sformatf("vec%0d_ack", k),   32'(m_ack), 32'(tbl[k].e_ack));
      chk($sformatf("vec%0d_err", k),   32'(m_err), 32'h0);
      chk($sformatf("vec%0d_cyc_o", k), 32'(wb.cyc_o), 32'(tbl[k].e_cyc));
      chk($sformatf("vec%0d_dat_r", k), 32'(m_dat_r), 32'(tbl[k].d));
    end

    // Slave never acks: error 16 cycles after stb_o rises, then next requester.
    drive(1, 3'b000, 3'b000, 0, 16'h0);
    t0 = -1; t1 = -1;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      drive(0, 3'b011, 3'b011, 0, 16'h0);
      if (t0 < 0 && wb.stb_o) t0 = c;
      if (m_err != '0) begin
        t1 = c;
        chk("timeout_err_owner", 32'(m_err), 32'h1);
        chk("timeout_cyc_o_low", 32'(wb.cyc_o), 32'h0);
      end
    end
    chk("timeout_seen", 32'(t1 >= 0), 32'h1);
    chk("timeout_latency", 32'(t1 - t0), 32'(TO));
    drive(0, 3'b011, 3'b011, 0, 16'h0);
    chk("timeout_err_one_cycle", 32'(m_err), 32'h0);
    chk("timeout_idle_after", 32'(grant), 32'h0);
    drive(0, 3'b011, 3'b011, 0, 16'h0);
    chk("timeout_next_owner", 32'(grant), 32'h2);
    drive(0, 3'b000, 3'b000, 0, 16'h0);

    // Ack arriving in the cycle the counter would expire.
    drive(1, 3'b000, 3'b000, 0, 16'h0);
    t0 = -1; saw_ack = 1'b0;
    for (int c = 0; c < 25; c++) begin
      ra = (t0 >= 0) && (c == t0 + TO - 1);
      drive(0, 3'b001, 3'b001, ra, 16'h55AA);
      if (t0 < 0 && wb.stb_o) t0 = c;
      if (ra) begin
        saw_ack = 1'b1;
        chk("late_ack_delivered", 32'(m_ack), 32'h1);
      end
      if (t0 >= 0 && c >= t0 + TO - 1 && c <= t0 + TO + 2)
        chk("late_ack_no_err", 32'(m_err), 32'h0);
    end
    chk("late_ack_seen", 32'(saw_ack), 32'h1);
    drive(0, 3'b000, 3'b000, 0, 16'h0);

    // Multi-beat hold by master 0 while master 2 waits.
    m_we[0] = 1'b1; m_adr[0] = GAME_MODE; m_dat_w[0] = 16'hBEEF;
    drive(1, 3'b000, 3'b000, 0, 16'h0);
    drive(0, 3'b101, 3'b101, 0, 16'h0);
    chk("burst_arb_idle", 32'(grant), 32'h0);
    for (int b = 0; b < 3; b++) begin
      drive(0, 3'b101, 3'b101, 1, 16'h0);
      chk($sformatf("burst%0d_grant", b), 32'(grant), 32'h1);
      chk($sformatf("burst%0d_cyc_o", b), 32'(wb.cyc_o), 32'h1);
      chk($sformatf("burst%0d_ack", b), 32'(m_ack), 32'h1);
    end
    chk("burst_we_o", 32'(wb.we_o), 32'h1);
    chk("burst_adr_o", 32'(wb.adr_o), 32'(GAME_MODE));
    chk("burst_dat_o", 32'(wb.dat_o), 32'hBEEF);
    drive(0, 3'b100, 3'b100, 0, 16'h0);
    chk("burst_release_grant", 32'(grant), 32'h1);
    chk("burst_release_cyc_o", 32'(wb.cyc_o), 32'h0);
    drive(0, 3'b100, 3'b100, 0, 16'h0);
    chk("burst_gap", 32'(grant), 32'h0);
    drive(0, 3'b100, 3'b100, 0, 16'h0);
    chk("burst_next_owner", 32'(grant), 32'h4);
    chk("burst_next_adr_o", 32'(wb.adr_o), 32'(GAMES_LOST));
    drive(0, 3'b000, 3'b000, 0, 16'h0);
    m_we[0] = 1'b0;

    // Reset mid-transfer: pointer is moved to 1 first so its clearing is visible.
    drive(1, 3'b000, 3'b000, 0, 16'h0);
    drive(0, 3'b001, 3'b001, 0, 16'h0);
    drive(0, 3'b001, 3'b001, 1, 16'h0);
    drive(0, 3'b000, 3'b000, 0, 16'h0);
    drive(0, 3'b010, 3'b010, 0, 16'h0);
    drive(0, 3'b010, 3'b010, 0, 16'h0);
    chk("rst_mid_owner", 32'(grant), 32'h2);
    drive(1, 3'b010, 3'b010, 0, 16'h0);
    chk("rst_mid_err_during", 32'(m_err), 32'h0);
    drive(0, 3'b011, 3'b011, 0, 16'h0);
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_cyc_o", 32'(wb.cyc_o), 32'h0);
    chk("rst_mid_err", 32'(m_err), 32'h0);
    drive(0, 3'b011, 3'b011, 0, 16'h0);
    chk("rst_mid_ptr_zero", 32'(grant), 32'h1);
    drive(0, 3'b000, 3'b000, 0, 16'h0);

    // Random traffic against the reference model.
    model_reset();
    rc = '0; rs = '0; stall = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) stall = ($urandom_range(0, 1) == 1);
      rr = (n == 0) || ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (rc[i]) rc[i] = ($urandom_range(0, stall ? 39 : 5) != 0);
        else       rc[i] = ($urandom_range(0, 3) == 0);
        rs[i] = rc[i] && ($urandom_range(0, 7) != 0);
      end
      ra = !stall && ($urandom_range(0, 2) == 0);
      drive(rr, rc, rs, ra, 16'($urandom));
      for (int i = 0; i < N; i++) begin
        m_we[i]    = 1'($urandom);
        m_adr[i]   = 8'(2 * $urandom_range(0, 9));
        m_dat_w[i] = 16'($urandom);
      end
      #1;
      model_compare();
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/settings_bus_arbiter.md
SETTINGS_BUS_ARBITER -- requirements
Module: settings_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of requesters sharing the game-settings register slave (2..4 legal).
REQ-002 Parameter TIMEOUT_CYCLES, default 16: number of cycles without slave ack before the arbiter aborts a transfer.
REQ-003 Port clk  input  1: single system clock; all logic is on the rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port m_cyc, m_stb, m_we  input  NUM_MASTERS each: per-master Wishbone cycle, strobe and write-enable.
REQ-006 Port m_adr  input  NUM_MASTERS x 8: per-master byte address; registers sit at even addresses 0x00..0x12.
REQ-007 Port m_dat_w  input  NUM_MASTERS x 16: per-master write data.
REQ-008 Port m_ack, m_err  output  NUM_MASTERS each: per-master acknowledge and timeout-error pulses.
REQ-009 Port m_dat_r  output  16: read data, shared by all masters and qualified by m_ack.
REQ-010 Port s_bus  wishbone_if.master  -: downstream port to the settings slave (cyc_o, stb_o, we_o, adr_o, dat_o out; dat_i, ack_i in).
REQ-011 Port grant  output  NUM_MASTERS: one-hot current owner, all-zero when idle.

Function
REQ-012 States IDLE, GRANTED, ABORT; encoding is defined in the shared package.
REQ-013 IDLE: when any m_cyc is high, grant the requester at or after rr_ptr in round-robin order; move to GRANTED on the next edge.
REQ-014 Grant is registered: s_bus cyc_o/stb_o/we_o/adr_o/dat_o mirror the granted master combinationally from the first GRANTED cycle onward.
REQ-015 GRANTED: the grant is held while the owner's m_cyc stays high, so multi-beat cycles are never interleaved with another master.
REQ-016 ack_i is routed only to the owner's m_ack in the same cycle; m_dat_r = s_bus.dat_i; non-owners see m_ack = 0 and m_err = 0.
REQ-017 Owner drops m_cyc: return to IDLE; rr_ptr = owner+1, wrapping NUM_MASTERS-1 to 0; arbitration for the next owner takes one cycle.
REQ-018 Timeout counter: cleared on grant and on each ack_i; counts cycles where stb_o is high and ack_i is low.
REQ-019 Timeout: when the counter reaches TIMEOUT_CYCLES, enter ABORT and drive the owner's m_err high for exactly one cycle with cyc_o low.
REQ-020 ABORT: return to IDLE on the next cycle and advance rr_ptr as in REQ-017.
REQ-021 ack_i arriving in the same cycle as the timeout takes priority: it is delivered as ack and no error is raised.
REQ-022 ack_i while in IDLE or ABORT is ignored.
REQ-023 A requester whose m_cyc falls before it is granted is not granted.
REQ-024 Simultaneous requests are served in strict round-robin order, so each master waits at most NUM_MASTERS-1 tenures.

Reset
REQ-025 While rst is high: state = IDLE, grant = 0, rr_ptr = 0, timeout counter = 0, all m_ack/m_err = 0, s_bus cyc_o/stb_o/we_o = 0, adr_o/dat_o = 0.
REQ-026 Reset during GRANTED aborts the transfer without raising m_err; cyc_o is low on the cycle after rst is sampled.

Structure
REQ-027 The state enum, the ADDR_W = 8 and DATA_W = 16 constants, and the register address localparams (ROW_COLUMN_NUMBER 0x00 through GAMES_LOST 0x12) belong in game_pkg.
REQ-028 The round-robin selection is one sub-module, rr_priority_picker (request vector + pointer -> one-hot grant); all other logic stays in the top module.

Verification
REQ-029 Scenario: master 1 alone reads 0x04 from a slave model returning 0x0096 with 1-cycle ack -> grant = 0b010, m_ack[1] one pulse, m_dat_r = 0x0096, m_ack[0] and m_ack[2] stay 0.
REQ-030 Scenario: masters 0, 1 and 2 request in the same cycle from reset -> owners in order 0, 1, 2, each tenure separated by one IDLE cycle.
REQ-031 Scenario: master 0 holds cyc for 3 beats while master 2 requests -> no grant to master 2 until master 0's cyc falls; cyc_o stays high across all 3 beats.
REQ-032 Scenario: slave never acks, TIMEOUT_CYCLES = 16 -> m_err for the owner pulses exactly 16 cycles after stb_o rises, then state = IDLE and the next requester is granted.
REQ-033 Scenario: ack_i coincides with the timeout cycle -> m_ack pulses and m_err stays 0.
REQ-034 Scenario: rst asserted for 1 cycle mid-transfer -> grant = 0 and cyc_o = 0 on the following cycle, rr_ptr = 0, no m_err.
